// File: rtl/sipo_deserializer_pkg.sv
// Shared types for the SIPO deserializer: FSM state encoding and counter sizing.
package sipo_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_PAR   = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      PAR   = ST_PAR
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, parallel output handshake and status bundle of the deserializer.
interface sipo_deserializer_if #(
   parameter int WIDTH = 8
);
   logic             d;
   logic             d_valid;
   logic             start;
   logic             q_ready;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             busy;
   logic             overrun;
   logic             parity_err;

   modport master (
      output d, d_valid, start, q_ready,
      input  q, q_valid, busy, overrun, parity_err
   );

   modport slave (
      input  d, d_valid, start, q_ready,
      output q, q_valid, busy, overrun, parity_err
   );
endinterface

// File: rtl/sipo_deserializer_out_slot.sv
// Output word register with valid/ready handshake and sticky overrun flag.
module sipo_out_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   input  logic             perr,
   input  logic             q_ready,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             overrun,
   output logic             parity_err
);

   logic slot_free;

   // a held word handed off this cycle frees the slot for a same-edge reload
   assign slot_free = !q_valid || q_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         q          <= '0;
         q_valid    <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
      end else if (load) begin
         if (slot_free) begin
            q          <= word;
            parity_err <= perr;
            q_valid    <= 1'b1;
         end else begin
            overrun    <= 1'b1;
         end
      end else if (q_valid && q_ready) begin
         q_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel deserializer; define PARITY_CHECK_EN to expect a
// trailing even-parity bit per frame and report parity_err with each word.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   sipo_deserializer_if.slave bus
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic             restart;
   logic             last_data;
   logic             done;
   logic [WIDTH-1:0] word;
   logic             perr;

   assign restart   = bus.d_valid && bus.start;
   assign last_data = bus.d_valid && !bus.start && (state == SHIFT) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (restart) state_nxt = SHIFT;
`ifdef PARITY_CHECK_EN
         SHIFT:   if (last_data) state_nxt = PAR;
         PAR:     if (restart) state_nxt = SHIFT;
                  else if (bus.d_valid) state_nxt = IDLE;
`else
         SHIFT:   if (last_data) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != IDLE);
`ifdef PARITY_CHECK_EN
      done = (state == PAR) && bus.d_valid && !bus.start;
      word = shreg;
      perr = ^{shreg, bus.d};
`else
      done = last_data;
      word = {shreg[WIDTH-2:0], bus.d};
      perr = 1'b0;
`endif
   end

   // restart has priority in every state, so a start bit always becomes the MSB
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (restart) begin
         shreg <= {shreg[WIDTH-2:0], bus.d};
         cnt   <= CNT_W'(1);
      end else if (done) begin
         cnt   <= '0;
      end else if (bus.d_valid && (state == SHIFT)) begin
         shreg <= {shreg[WIDTH-2:0], bus.d};
         cnt   <= cnt + 1'b1;
      end
   end

   sipo_out_slot #(
      .WIDTH(WIDTH)
   ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (done),
      .word       (word),
      .perr       (perr),
      .q_ready    (bus.q_ready),
      .q          (bus.q),
      .q_valid    (bus.q_valid),
      .overrun    (bus.overrun),
      .parity_err (bus.parity_err)
   );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer; directed frames, monitor pops on handshake.
module tb_sipo_deserializer;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] w;
      logic             p;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   exp_t sb[$];
   exp_t e;

   sipo_deserializer_if #(.WIDTH(WIDTH)) bus ();

   sipo_deserializer #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && bus.q_valid && bus.q_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_word q=%h expected none", bus.q);
         end else begin
            e = sb.pop_front();
            if (bus.q !== e.w || bus.parity_err !== e.p) begin
               n_err++;
               $display("FAIL word q=%h perr=%b expected q=%h perr=%b",
                        bus.q, bus.parity_err, e.w, e.p);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic dv, input logic db, input logic st);
      bus.d_valid = dv;
      bus.d       = db;
      bus.start   = st;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [WIDTH-1:0] w, input logic p);
      sb.push_back('{w: w, p: p});
   endtask

   // all bits but the one that completes the frame
   task automatic send_body(input logic [WIDTH-1:0] w, input int gap);
      for (int i = WIDTH - 1; i >= 1; i--) begin
         drive(1'b1, w[i], i == WIDTH - 1);
         repeat (gap) idle();
      end
`ifdef PARITY_CHECK_EN
      drive(1'b1, w[0], 1'b0);
      repeat (gap) idle();
`endif
   endtask

   task automatic send_last(input logic [WIDTH-1:0] w, input logic flip);
`ifdef PARITY_CHECK_EN
      drive(1'b1, (^w) ^ flip, 1'b0);
`else
      drive(1'b1, w[0] ^ (flip & 1'b0), 1'b0);
`endif
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] w, input int gap);
      send_body(w, gap);
      send_last(w, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      bus.d       = 1'b0;
      bus.d_valid = 1'b0;
      bus.start   = 1'b0;
      bus.q_ready = 1'b0;

      // 1: reset state and single frame latency
      do_reset();
      check("rst_q",          32'(bus.q),          32'h0);
      check("rst_q_valid",    32'(bus.q_valid),    32'h0);
      check("rst_busy",       32'(bus.busy),       32'h0);
      check("rst_overrun",    32'(bus.overrun),    32'h0);
      check("rst_parity_err", 32'(bus.parity_err), 32'h0);

      bus.q_ready = 1'b1;
      push(8'hA5, 1'b0);
      send_body(8'hA5, 0);
      check("lat_before_valid", 32'(bus.q_valid), 32'h0);
      check("lat_busy",         32'(bus.busy),    32'h1);
      send_last(8'hA5, 1'b0);
      check("lat_valid",    32'(bus.q_valid), 32'h1);
      check("lat_q",        32'(bus.q),       32'hA5);
      check("lat_idle",     32'(bus.busy),    32'h0);
      idle();
      check("lat_one_cycle", 32'(bus.q_valid), 32'h0);

      // 2a: backpressure drops the second word
      bus.q_ready = 1'b0;
      push(8'h3C, 1'b0);
      send_frame(8'h3C, 0);
      send_frame(8'hF0, 0);
      check("bp_q_hold",  32'(bus.q),       32'h3C);
      check("bp_valid",   32'(bus.q_valid), 32'h1);
      check("bp_overrun", 32'(bus.overrun), 32'h1);
      idle();
      check("bp_q_still", 32'(bus.q),       32'h3C);
      bus.q_ready = 1'b1;
      idle();
      check("bp_drained", 32'(bus.q_valid), 32'h0);

      // 2b: handshake in the completion cycle allows same-edge reload
      do_reset();
      check("bp2_overrun_rst", 32'(bus.overrun), 32'h0);
      bus.q_ready = 1'b0;
      push(8'h3C, 1'b0);
      send_frame(8'h3C, 0);
      send_body(8'hF0, 0);
      bus.q_ready = 1'b1;
      push(8'hF0, 1'b0);
      send_last(8'hF0, 1'b0);
      check("bp2_q",       32'(bus.q),       32'hF0);
      check("bp2_valid",   32'(bus.q_valid), 32'h1);
      check("bp2_overrun", 32'(bus.overrun), 32'h0);
      idle();
      check("bp2_drained", 32'(bus.q_valid), 32'h0);

      // 3: sparse strobes, then stray bits in IDLE
      push(8'h81, 1'b0);
      send_body(8'h81, 2);
      send_last(8'h81, 1'b0);
      check("gap_q", 32'(bus.q), 32'h81);
      idle();
      for (int i = 0; i < 5; i++) drive(1'b1, i[0], 1'b0);
      idle();
      check("stray_busy",  32'(bus.busy),    32'h0);
      check("stray_valid", 32'(bus.q_valid), 32'h0);

      // 4: restart after 3 bits of 0xFF
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      push(8'h5A, 1'b0);
      send_frame(8'h5A, 0);
      check("restart_q", 32'(bus.q), 32'h5A);
      idle();
      check("restart_overrun", 32'(bus.overrun), 32'h0);

      // 5: reset mid-frame discards the partial frame
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      idle();
      check("midrst_valid", 32'(bus.q_valid), 32'h0);
      check("midrst_busy",  32'(bus.busy),    32'h0);
      push(8'h0F, 1'b0);
      send_frame(8'h0F, 0);
      check("midrst_q", 32'(bus.q), 32'h0F);
      idle();

`ifdef PARITY_CHECK_EN
      // 6: parity bit handling
      push(8'hA5, 1'b0);
      send_body(8'hA5, 0);
      check("par_wait", 32'(bus.q_valid), 32'h0);
      send_last(8'hA5, 1'b0);
      check("par_ok_valid", 32'(bus.q_valid),    32'h1);
      check("par_ok_err",   32'(bus.parity_err), 32'h0);
      idle();
      push(8'hA5, 1'b1);
      send_body(8'hA5, 0);
      send_last(8'hA5, 1'b1);
      check("par_bad_err", 32'(bus.parity_err), 32'h1);
      idle();
`endif

      for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
